exception_ctrl: RTL
===================

EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 mem_valid  in  1  MEM-stage instruction valid this cycle.
REQ-004 mem_pc  in  32  MEM-stage instruction PC.
REQ-005 mem_in_ds  in  1  MEM-stage instruction is in a branch delay slot.
REQ-006 mem_exc  in  7  flags {ades, adel_ld, bp, sys, ov, ri, adel_if}, bit0 = adel_if.
REQ-007 mem_eret  in  1  MEM-stage instruction is ERET.
REQ-008 mem_addr  in  32  data virtual address of the load/store.
REQ-009 hw_int  in  6  raw hardware interrupt lines.
REQ-010 status_in, cause_in, epc_in  in  32 each  CP0 Status, Cause and EPC current values.
REQ-011 cp0_we  out  32  per-register CP0 write strobe; only bits 8, 12, 13, 14 are used.
REQ-012 cp0_epc, cp0_badvaddr  out  32 each  EPC and BadVAddr write data.
REQ-013 cp0_exl, cp0_bd  out  1 each  EXL and Cause.BD write data.
REQ-014 cp0_exc_code  out  5  Cause.ExcCode write data.
REQ-015 cp0_hw_int  out  6  registered hw_int passed to CP0.
REQ-016 flush  out  1  kills all pipeline stages younger than WB.
REQ-017 exc_busy  out  1  stalls the pipeline front end.
REQ-018 redirect_valid  out  1  fetch redirect request.
REQ-019 redirect_pc  out  32  fetch redirect target.
REQ-020 redirect_ready  in  1  fetch accepts the redirect.

Function
REQ-021 hw_int_q SHALL register hw_int every cycle; cp0_hw_int = hw_int_q.
REQ-022 int_pend SHALL equal status_in[0] & ~status_in[1] & |(status_in[15:8] & {hw_int_q, cause_in[9:8]}).
REQ-023 FSM states SHALL be IDLE, COMMIT, REDIRECT; reset state IDLE.
REQ-024 Trigger: in IDLE with mem_valid & (int_pend | |mem_exc | mem_eret), the block SHALL capture the event and move to COMMIT next cycle; otherwise it SHALL stay in IDLE.
REQ-025 Priority SHALL be int > adel_if > ri > ov > sys > bp > adel_ld > ades > eret; the ExcCodes SHALL be 0, 4, 10, 12, 8, 9, 4, 5 respectively.
REQ-026 Captured EPC SHALL be mem_pc-4 when mem_in_ds=1, else mem_pc; cp0_bd = mem_in_ds.
REQ-027 Captured BadVAddr SHALL be mem_pc for adel_if and mem_addr for adel_ld/ades; cp0_we[8] SHALL be set only for these three causes.
REQ-028 COMMIT (one cycle), exception case: cp0_we[12], cp0_we[13] and cp0_we[14] SHALL be 1, with cp0_exl=1; redirect_pc SHALL be latched to 32'hBFC00380.
REQ-029 COMMIT, ERET case: only cp0_we[12] SHALL be 1, with cp0_exl=0; redirect_pc SHALL be latched to epc_in.
REQ-030 COMMIT SHALL always go to REDIRECT.
REQ-031 REDIRECT: redirect_valid=1 and redirect_pc SHALL be held stable until redirect_ready=1; on that cycle the block SHALL return to IDLE.
REQ-032 flush SHALL be 1 in COMMIT and in REDIRECT.
REQ-033 exc_busy SHALL be 1 whenever state != IDLE.
REQ-034 mem_valid SHALL be ignored outside IDLE; no second event is captured while busy.
REQ-035 cp0_we SHALL be all-zero outside COMMIT.
REQ-036 All data outputs SHALL be registered; no input reaches an output in the same cycle.
REQ-037 Arithmetic SHALL be 32-bit modulo 2^32: mem_pc=0 with mem_in_ds gives EPC 32'hFFFFFFFC.

Reset
REQ-038 On rst: state=IDLE, hw_int_q=0, all outputs 0, redirect_pc=0.
REQ-039 rst in COMMIT or REDIRECT SHALL abort the operation with no CP0 write on the following cycle.

Structure
REQ-040 A shared package SHALL hold the ExcCode constants, the 32'hBFC00380 entry vector, the CP0 register indices (8, 12, 13, 14) and the FSM state enum.
REQ-041 No sub-module; a single module.

Verification
REQ-042 ov, mem_pc=0x80001000, mem_in_ds=0 -> COMMIT: cp0_we=0x7000, code=12, epc=0x80001000; then redirect to 0xBFC00380.
REQ-043 adel_ld, mem_addr=0x80000003, mem_in_ds=1, pc=0x80000010 -> cp0_we[8]=1, badvaddr=0x80000003, epc=0x8000000C, bd=1, code=4.
REQ-044 status_in=0x0000FF01, hw_int=6'b000001, plus ri -> code=0; with status_in[1]=1 instead -> code=10.
REQ-045 eret, epc_in=0x80002000 -> cp0_we=0x1000, exl=0, redirect_pc=0x80002000.
REQ-046 redirect_ready held 0 for 5 cycles -> redirect_valid, redirect_pc and flush stable; a new mem_exc during the wait is ignored.
REQ-047 rst asserted in REDIRECT -> next cycle IDLE, all outputs 0.

Source files
------------

// File: rtl/exception_ctrl_pkg.sv
// Shared constants for the exception controller: ExcCodes, entry vector,
// CP0 register indices, mem_exc flag positions and the FSM state encoding.
package exception_ctrl_pkg;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

    localparam int CP0_BADVADDR = 8;
    localparam int CP0_STATUS   = 12;
    localparam int CP0_CAUSE    = 13;
    localparam int CP0_EPC      = 14;

    // Bit positions inside mem_exc
    localparam int EXB_ADEL_IF = 0;
    localparam int EXB_RI      = 1;
    localparam int EXB_OV      = 2;
    localparam int EXB_SYS     = 3;
    localparam int EXB_BP      = 4;
    localparam int EXB_ADEL_LD = 5;
    localparam int EXB_ADES    = 6;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COMMIT   = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

endpackage

// File: rtl/exception_ctrl.sv
// Precise exception / ERET controller: captures a MEM-stage event, writes CP0
// for one cycle, then holds a fetch redirect until it is accepted.
module exception_ctrl
    import exception_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic        mem_in_ds,
    input  logic [6:0]  mem_exc,
    input  logic        mem_eret,
    input  logic [31:0] mem_addr,
    input  logic [5:0]  hw_int,
    input  logic [31:0] status_in,
    input  logic [31:0] cause_in,
    input  logic [31:0] epc_in,
    output logic [31:0] cp0_we,
    output logic [31:0] cp0_epc,
    output logic [31:0] cp0_badvaddr,
    output logic        cp0_exl,
    output logic        cp0_bd,
    output logic [4:0]  cp0_exc_code,
    output logic [5:0]  cp0_hw_int,
    output logic        flush,
    output logic        exc_busy,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
);

    state_t      state_reg;
    logic [5:0]  hw_int_q;
    logic        eret_reg;

    logic        int_pend;
    logic        trigger;
    logic [4:0]  code_next;
    logic [31:0] badv_next;
    logic        badv_we_next;
    logic        eret_next;
    logic [31:0] epc_next;
    logic [31:0] we_next;

    assign int_pend = status_in[0] & ~status_in[1]
                    & (|(status_in[15:8] & {hw_int_q, cause_in[9:8]}));
    assign trigger  = mem_valid & (int_pend | (|mem_exc) | mem_eret);
    assign epc_next = mem_in_ds ? (mem_pc - 32'd4) : mem_pc;

    // Fixed-priority cause selection; ERET is taken only when nothing else is pending
    always_comb begin
        code_next    = EXC_INT;
        badv_next    = '0;
        badv_we_next = 1'b0;
        eret_next    = 1'b0;
        if (int_pend) begin
            code_next = EXC_INT;
        end else if (mem_exc[EXB_ADEL_IF]) begin
            code_next    = EXC_ADEL;
            badv_next    = mem_pc;
            badv_we_next = 1'b1;
        end else if (mem_exc[EXB_RI]) begin
            code_next = EXC_RI;
        end else if (mem_exc[EXB_OV]) begin
            code_next = EXC_OV;
        end else if (mem_exc[EXB_SYS]) begin
            code_next = EXC_SYS;
        end else if (mem_exc[EXB_BP]) begin
            code_next = EXC_BP;
        end else if (mem_exc[EXB_ADEL_LD]) begin
            code_next    = EXC_ADEL;
            badv_next    = mem_addr;
            badv_we_next = 1'b1;
        end else if (mem_exc[EXB_ADES]) begin
            code_next    = EXC_ADES;
            badv_next    = mem_addr;
            badv_we_next = 1'b1;
        end else begin
            eret_next = 1'b1;
        end
    end

    always_comb begin
        we_next = '0;
        we_next[CP0_STATUS] = 1'b1;
        if (!eret_next) begin
            we_next[CP0_CAUSE]    = 1'b1;
            we_next[CP0_EPC]      = 1'b1;
            we_next[CP0_BADVADDR] = badv_we_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            hw_int_q       <= '0;
            eret_reg       <= 1'b0;
            cp0_we         <= '0;
            cp0_epc        <= '0;
            cp0_badvaddr   <= '0;
            cp0_exl        <= 1'b0;
            cp0_bd         <= 1'b0;
            cp0_exc_code   <= '0;
            flush          <= 1'b0;
            exc_busy       <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            hw_int_q <= hw_int;
            cp0_we   <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (trigger) begin
                        state_reg    <= ST_COMMIT;
                        eret_reg     <= eret_next;
                        cp0_we       <= we_next;
                        cp0_epc      <= epc_next;
                        cp0_badvaddr <= badv_next;
                        cp0_exl      <= ~eret_next;
                        cp0_bd       <= mem_in_ds;
                        cp0_exc_code <= code_next;
                        flush        <= 1'b1;
                        exc_busy     <= 1'b1;
                    end
                end
                ST_COMMIT: begin
                    state_reg      <= ST_REDIRECT;
                    redirect_valid <= 1'b1;
                    redirect_pc    <= eret_reg ? epc_in : EXC_VECTOR;
                end
                ST_REDIRECT: begin
                    if (redirect_ready) begin
                        state_reg      <= ST_IDLE;
                        redirect_valid <= 1'b0;
                        flush          <= 1'b0;
                        exc_busy       <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign cp0_hw_int = hw_int_q;

    logic unused_bits;
    assign unused_bits = ^{status_in[31:16], status_in[7:2], cause_in[31:10], cause_in[7:0]};

endmodule
